// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter sequencer and run-control FSM for the single-cycle MIPS core.
// Owns the instruction fetch address (ReadAddr), computes the next PC from the
// core's Zero/Branch/Jump/SEImm/JumpValue outputs, and provides halt / run /
// single-step control, an address breakpoint and a saturating retired count.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   Zero, Branch, Jump  core flags for the instruction at ReadAddr
//   SEImm, JumpValue    sign-extended immediate and instr[25:0] from core
//   run_req, halt_req,  level-sensitive run-control requests, sampled in HALT
//   step_req            (halt_req is also sampled in RUN)
//   bp_en, bp_addr      breakpoint enable and PC
//   ReadAddr            current PC to the core
//   commit              current instruction is architecturally executed;
//                       integration ANDs it into RegWrite and MemWrite
//   state               FSM state: 00 HALT, 01 RUN, 10 STEP
//   step_done           one-cycle pulse in the HALT cycle following a STEP
//   bp_hit              sticky: last halt was caused by the breakpoint
//   retired             retired-instruction count, saturating
//
// Request semantics: run_req/halt_req/step_req are plain levels with no
// acknowledge. A request sampled at edge N changes state at edge N, so commit
// (decoded from the state flop only) reflects it from cycle N+1 onward.
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Zero,
    input  logic              Branch,
    input  logic              Jump,
    input  logic [31:0]       SEImm,
    input  logic [25:0]       JumpValue,
    input  logic              run_req,
    input  logic              halt_req,
    input  logic              step_req,
    input  logic              bp_en,
    input  logic [PC_W-1:0]   bp_addr,
    output logic [PC_W-1:0]   ReadAddr,
    output logic              commit,
    output logic [1:0]        state,
    output logic              step_done,
    output logic              bp_hit,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } state_t;

    localparam logic [PC_W-1:0] PC_INC = PC_W'(4);

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              bp_hit_q, bp_hit_d;
    logic              step_done_q, step_done_d;

    logic [PC_W-1:0]   pc4;
    logic [PC_W-1:0]   jump_tgt;
    logic [PC_W-1:0]   br_off;
    logic [PC_W-1:0]   next_pc;
    logic [CNT_W-1:0]  retired_inc;
    logic              bp_match;

    // Immediate bits above the PC width cannot affect a wrapped PC.
    logic unused_imm_bits;
    assign unused_imm_bits = ^{SEImm[31:PC_W-2], JumpValue[25:PC_W-2]};

    // -------------------------------------------------------------------------
    // Next-PC datapath. All arithmetic wraps mod 2^PC_W, so a negative branch
    // offset falls out of the truncated sign-extended immediate.
    // -------------------------------------------------------------------------
    always_comb begin
        pc4      = pc_q + PC_INC;
        jump_tgt = {JumpValue[PC_W-3:0], 2'b00};
        br_off   = {SEImm[PC_W-3:0], 2'b00};
        if (Jump) begin
            next_pc = jump_tgt;
        end else if (Branch && Zero) begin
            next_pc = pc4 + br_off;
        end else begin
            next_pc = pc4;
        end
    end

    assign bp_match    = bp_en && (next_pc == bp_addr);
    assign retired_inc = (&retired_q) ? retired_q : retired_q + CNT_W'(1);

    // -------------------------------------------------------------------------
    // Run-control FSM: next state and datapath updates.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        retired_d   = retired_q;
        bp_hit_d    = bp_hit_q;
        step_done_d = 1'b0;

        case (state_q)
            ST_HALT: begin
                // halt_req outranks step, step outranks run.
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (step_req) begin
                    state_d  = ST_STEP;
                    bp_hit_d = 1'b0;
                end else if (run_req) begin
                    state_d  = ST_RUN;
                    bp_hit_d = 1'b0;
                end
            end
            ST_RUN: begin
                pc_d      = next_pc;
                retired_d = retired_inc;
                // The breakpoint stops before the instruction at bp_addr runs;
                // if halt_req arrives together, the result is the same HALT
                // but bp_hit still records the breakpoint.
                if (bp_match) begin
                    pc_d     = bp_addr;
                    state_d  = ST_HALT;
                    bp_hit_d = 1'b1;
                end else if (halt_req) begin
                    state_d = ST_HALT;
                end
            end
            ST_STEP: begin
                // Breakpoint deliberately ignored so a user can step past it.
                pc_d        = next_pc;
                retired_d   = retired_inc;
                state_d     = ST_HALT;
                step_done_d = 1'b1;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_HALT;
            pc_q        <= RESET_PC;
            retired_q   <= '0;
            bp_hit_q    <= 1'b0;
            step_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            retired_q   <= retired_d;
            bp_hit_q    <= bp_hit_d;
            step_done_q <= step_done_d;
        end
    end

    // commit comes from the state flop only; the illegal encoding reads as 0.
    assign commit    = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign ReadAddr  = pc_q;
    assign state     = state_q;
    assign step_done = step_done_q;
    assign bp_hit    = bp_hit_q;
    assign retired   = retired_q;

endmodule
